// File: rtl/bram_arb_pkg.sv
// Shared types and the round-robin pick function for the BRAM read arbiter.
package bram_arb_pkg;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef logic [MAX_REQ-1:0] grant_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // Unused upper request bits are zero, so scanning all MAX_REQ slots modulo 8
  // behaves exactly like a scan modulo NUM_REQ.
  function automatic grant_t rr_pick(input grant_t valid, input idx_t last_grant);
    grant_t pick;
    idx_t   idx;
    pick = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = last_grant + idx_t'(k);
      if (valid[idx] && (pick == '0)) pick[idx] = 1'b1;
    end
    return pick;
  endfunction
endpackage

// File: rtl/bram_t.sv
// Read-only BRAM/ROM bus; the slave registers read_data one cycle after read_en.
interface bram_t #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input logic clk
);
  logic              read_en;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;

  modport master_read (input clk, output read_en, output read_addr, input read_data);
  modport slave_read  (input clk, input read_en, input read_addr, output read_data);
endinterface

// File: rtl/bram_read_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot pick plus the last_grant pointer.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant
);
  idx_t   last_grant;
  idx_t   grant_idx;
  grant_t valid_ext;
  grant_t pick;
  logic   unused_pick;

  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = req_valid;
  end

  assign pick        = rr_pick(valid_ext, last_grant);
  assign unused_pick = ^pick;

  always_comb begin
    grant     = reset_n ? pick[NUM_REQ-1:0] : '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = idx_t'(i);
    end
  end

  // A grant is only ever issued to a valid requester, so any grant is an acceptance.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant <= idx_t'(NUM_REQ - 1);
    end else if (|grant) begin
      last_grant <= grant_idx;
    end
  end
endmodule

// File: rtl/bram_read_arbiter.sv
// Shares one BRAM read port among NUM_REQ requesters with round-robin arbitration.
// Define BRAM_ARB_OUT_REG_EN to add an output register (2-cycle response latency).
module bram_read_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [DATA_W-1:0]              resp_data,
  bram_t.master_read                     bram
);
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0]  addr_sel;
  logic [ADDR_W-1:0]  addr_q;
  logic [NUM_REQ-1:0] tag_p0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .grant     (grant)
  );

  assign req_ready = grant;

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) addr_sel = addr_sel | req_addr[i];
    end
  end

  assign bram.read_en   = |grant;
  assign bram.read_addr = (|grant) ? addr_sel : addr_q;

  // Stage p0: address hold register and in-flight tag aligned with BRAM data.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_q <= '0;
      tag_p0 <= '0;
    end else begin
      if (|grant) addr_q <= addr_sel;
      tag_p0 <= grant;
    end
  end

`ifdef BRAM_ARB_OUT_REG_EN
  logic [NUM_REQ-1:0] tag_p1;
  logic [DATA_W-1:0]  data_p1;

  // Stage p1: optional output register on tag and data.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tag_p1  <= '0;
      data_p1 <= '0;
    end else begin
      tag_p1  <= tag_p0;
      data_p1 <= bram.read_data;
    end
  end

  assign resp_valid = reset_n ? tag_p1 : '0;
  assign resp_data  = data_p1;
`else
  assign resp_valid = reset_n ? tag_p0 : '0;
  assign resp_data  = reset_n ? bram.read_data : '0;
`endif
endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter: 2-requester and 3-requester instances with ROM models.
module tb_bram_read_arbiter;
`ifdef BRAM_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       a_valid;
  logic [1:0][9:0]  a_addr;
  logic [1:0]       a_ready, a_resp_valid;
  logic [7:0]       a_resp_data;
  logic [2:0]       b_valid;
  logic [2:0][9:0]  b_addr;
  logic [2:0]       b_ready, b_resp_valid;
  logic [7:0]       b_resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_t #(.ADDR_W(10), .DATA_W(8)) bus_a (.clk(clk));
  bram_t #(.ADDR_W(10), .DATA_W(8)) bus_b (.clk(clk));

  function automatic logic [7:0] rom_val(input logic [9:0] a);
    logic [15:0] t;
    t = {6'b0, a} * 16'd37 + 16'd11;
    return t[7:0];
  endfunction

  always_ff @(posedge clk) if (bus_a.read_en) bus_a.read_data <= rom_val(bus_a.read_addr);
  always_ff @(posedge clk) if (bus_b.read_en) bus_b.read_data <= rom_val(bus_b.read_addr);

  bram_read_arbiter #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(8)) dut_a (
    .clock(clk), .reset_n(reset_n), .req_valid(a_valid), .req_addr(a_addr),
    .req_ready(a_ready), .resp_valid(a_resp_valid), .resp_data(a_resp_data), .bram(bus_a)
  );

  bram_read_arbiter #(.NUM_REQ(3), .ADDR_W(10), .DATA_W(8)) dut_b (
    .clock(clk), .reset_n(reset_n), .req_valid(b_valid), .req_addr(b_addr),
    .req_ready(b_ready), .resp_valid(b_resp_valid), .resp_data(b_resp_data), .bram(bus_b)
  );

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0; a_valid = '0; b_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; a_valid = 2'b11; b_valid = 3'b111;
    a_addr = '0; b_addr = '0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); #1;
      checks++; if (a_ready !== 2'b00) begin errors++; $display("FAIL reset_ready c%0d got %b want 00", n, a_ready); end
      checks++; if (bus_a.read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en c%0d got %b want 0", n, bus_a.read_en); end
      checks++; if (a_resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid c%0d got %b want 00", n, a_resp_valid); end
      checks++; if (a_resp_data !== 8'h00) begin errors++; $display("FAIL reset_resp_data c%0d got %h want 00", n, a_resp_data); end
      checks++; if (bus_a.read_addr !== 10'd0) begin errors++; $display("FAIL reset_read_addr c%0d got %0d want 0", n, bus_a.read_addr); end
      checks++; if (b_ready !== 3'b000) begin errors++; $display("FAIL reset_ready_b c%0d got %b want 000", n, b_ready); end
    end
    @(negedge clk);
    reset_n = 1'b1; a_valid = '0; b_valid = '0;
  endtask

  task automatic test_single();
    logic [1:0] exp_rv;
    a_addr[0] = 10'd5; a_addr[1] = 10'd9;
    for (int n = 0; n < 4 + LAT; n++) begin
      @(negedge clk);
      a_valid = (n < 4) ? 2'b01 : 2'b00;
      #1;
      exp_rv = (n >= LAT && n - LAT < 4) ? 2'b01 : 2'b00;
      checks++; if (a_ready !== a_valid) begin errors++; $display("FAIL single_ready c%0d got %b want %b", n, a_ready, a_valid); end
      if (n < 4) begin
        checks++; if (bus_a.read_addr !== 10'd5) begin errors++; $display("FAIL single_addr c%0d got %0d want 5", n, bus_a.read_addr); end
      end
      checks++; if (a_resp_valid !== exp_rv) begin errors++; $display("FAIL single_resp_valid c%0d got %b want %b", n, a_resp_valid, exp_rv); end
      if (exp_rv != 2'b00) begin
        checks++; if (a_resp_data !== rom_val(10'd5)) begin errors++; $display("FAIL single_resp_data c%0d got %h want %h", n, a_resp_data, rom_val(10'd5)); end
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g, exp_rv;
    int         k;
    pulse_reset();
    a_addr[0] = 10'd0; a_addr[1] = 10'd1;
    for (int n = 0; n < 6 + LAT; n++) begin
      @(negedge clk);
      a_valid = (n < 6) ? 2'b11 : 2'b00;
      #1;
      exp_g = (n < 6) ? ((n % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++; if (a_ready !== exp_g) begin errors++; $display("FAIL contention_grant c%0d got %b want %b", n, a_ready, exp_g); end
      if (n < 6) begin
        checks++; if (bus_a.read_addr !== 10'(n % 2)) begin errors++; $display("FAIL contention_addr c%0d got %0d want %0d", n, bus_a.read_addr, n % 2); end
      end
      k = n - LAT;
      exp_rv = (k >= 0) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++; if (a_resp_valid !== exp_rv) begin errors++; $display("FAIL contention_resp_valid c%0d got %b want %b", n, a_resp_valid, exp_rv); end
      if (k >= 0) begin
        checks++; if (a_resp_data !== rom_val(10'(k % 2))) begin errors++; $display("FAIL contention_resp_data c%0d got %h want %h", n, a_resp_data, rom_val(10'(k % 2))); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_g, exp_rv;
    logic [9:0] exp_a;
    int         k;
    pulse_reset();
    b_addr[0] = 10'd7; b_addr[1] = 10'd8; b_addr[2] = 10'd9;
    for (int n = 0; n < 4 + LAT; n++) begin
      @(negedge clk);
      b_valid = (n < 4) ? 3'b101 : 3'b000;
      #1;
      exp_g = (n < 4) ? ((n % 2 == 0) ? 3'b001 : 3'b100) : 3'b000;
      exp_a = (n % 2 == 0) ? 10'd7 : 10'd9;
      checks++; if (b_ready !== exp_g) begin errors++; $display("FAIL wrap_grant c%0d got %b want %b", n, b_ready, exp_g); end
      if (n < 4) begin
        checks++; if (bus_b.read_addr !== exp_a) begin errors++; $display("FAIL wrap_addr c%0d got %0d want %0d", n, bus_b.read_addr, exp_a); end
      end
      k = n - LAT;
      exp_rv = (k >= 0) ? ((k % 2 == 0) ? 3'b001 : 3'b100) : 3'b000;
      checks++; if (b_resp_valid !== exp_rv) begin errors++; $display("FAIL wrap_resp_valid c%0d got %b want %b", n, b_resp_valid, exp_rv); end
      if (k >= 0) begin
        exp_a = (k % 2 == 0) ? 10'd7 : 10'd9;
        checks++; if (b_resp_data !== rom_val(exp_a)) begin errors++; $display("FAIL wrap_resp_data c%0d got %h want %h", n, b_resp_data, rom_val(exp_a)); end
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    a_valid = 2'b10; a_addr[1] = 10'd3;
    #1;
    checks++; if (a_ready !== 2'b10) begin errors++; $display("FAIL midreset_grant got %b want 10", a_ready); end
    @(negedge clk);
    reset_n = 1'b0; a_valid = 2'b00;
    #1;
    checks++; if (a_resp_valid !== 2'b00) begin errors++; $display("FAIL midreset_resp_in_reset got %b want 00", a_resp_valid); end
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++; if (a_resp_valid !== 2'b00) begin errors++; $display("FAIL midreset_resp_after c%0d got %b want 00", n, a_resp_valid); end
    end
  endtask

  task automatic test_idle();
    @(negedge clk);
    a_valid = 2'b01; a_addr[0] = 10'd12;
    #1;
    checks++; if (bus_a.read_en !== 1'b1) begin errors++; $display("FAIL idle_setup_en got %b want 1", bus_a.read_en); end
    checks++; if (bus_a.read_addr !== 10'd12) begin errors++; $display("FAIL idle_setup_addr got %0d want 12", bus_a.read_addr); end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      a_valid = 2'b00; a_addr[0] = 10'd100; a_addr[1] = 10'd200;
      #1;
      checks++; if (bus_a.read_en !== 1'b0) begin errors++; $display("FAIL idle_read_en c%0d got %b want 0", n, bus_a.read_en); end
      checks++; if (bus_a.read_addr !== 10'd12) begin errors++; $display("FAIL idle_read_addr c%0d got %0d want 12", n, bus_a.read_addr); end
      checks++; if (a_ready !== 2'b00) begin errors++; $display("FAIL idle_ready c%0d got %b want 00", n, a_ready); end
      if (n == LAT - 1) begin
        checks++; if (a_resp_valid !== 2'b01) begin errors++; $display("FAIL idle_last_resp got %b want 01", a_resp_valid); end
        checks++; if (a_resp_data !== rom_val(10'd12)) begin errors++; $display("FAIL idle_last_data got %h want %h", a_resp_data, rom_val(10'd12)); end
      end else begin
        checks++; if (a_resp_valid !== 2'b00) begin errors++; $display("FAIL idle_resp_valid c%0d got %b want 00", n, a_resp_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_mid_reset();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_read_arbiter.md
BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing one ROM/BRAM read port, legal range 2..8.
REQ-002 Parameter ADDR_W, default 10: read address width; SHALL equal $size(bram.read_addr).
REQ-003 Parameter DATA_W, default 8: read data width; SHALL equal $size(bram.read_data).
REQ-004 Port clock  input  1: single clock, rising edge; also the bram_t bus clock.
REQ-005 Port reset_n  input  1: reset, synchronous, active-low.
REQ-006 Port req_valid  input  NUM_REQ: per-requester read request.
REQ-007 Port req_addr  input  NUM_REQ x ADDR_W: per-requester read address.
REQ-008 Port req_ready  output  NUM_REQ: one-hot grant; a request is accepted in any cycle where req_valid[i] && req_ready[i].
REQ-009 Port resp_valid  output  NUM_REQ: one-hot; marks the requester that owns resp_data this cycle.
REQ-010 Port resp_data  output  DATA_W: read data returned to the owning requester.
REQ-011 Port bram  bram_t.master_read: drives read_en and read_addr, samples read_data; the ROM slave registers read_data one cycle after read_en.

Function
REQ-012 Arbitration SHALL be round-robin: the search starts at index (last_grant+1) mod NUM_REQ; the first index with req_valid set wins.
REQ-013 At most one req_ready bit SHALL be high per cycle; req_ready[i] SHALL be combinational from req_valid and the round-robin pointer.
REQ-014 req_ready SHALL be all-zero when req_valid is all-zero.
REQ-015 In a grant cycle, bram.read_en SHALL be 1 and bram.read_addr SHALL equal req_addr[granted]; otherwise read_en SHALL be 0 and read_addr SHALL hold its last value.
REQ-016 last_grant SHALL update only on an accepted request.
REQ-017 The arbiter SHALL keep an in-flight tag of the one-hot grant, delayed to match the BRAM latency.
REQ-018 Default response latency SHALL be 1 cycle: resp_valid equals the tag and resp_data equals bram.read_data.
REQ-019 Back-to-back grants SHALL give one accepted request per cycle, so full throughput; responses return in grant order.
REQ-020 Responses have no backpressure; a requester SHALL consume resp_data in the cycle resp_valid is high.
REQ-021 A lone requester holding req_valid high SHALL be granted every cycle.
REQ-022 When the round-robin pointer wraps from index NUM_REQ-1 to 0, priority SHALL be unchanged except for the rotation.

Reset
REQ-023 While reset_n=0 at a clock edge: req_ready=0, resp_valid=0, resp_data=0, bram.read_en=0, bram.read_addr=0, last_grant=NUM_REQ-1 (so index 0 has first priority).
REQ-024 Reset asserted mid-operation SHALL discard in-flight tags; no resp_valid SHALL appear in the cycle after reset deasserts.

Configuration
REQ-025 Macro BRAM_ARB_OUT_REG_EN defined: resp_data and resp_valid pass through one more register, so latency is 2 cycles; the tag pipeline is 2 deep; throughput is unchanged.
REQ-026 Macro BRAM_ARB_OUT_REG_EN undefined: latency is 1 cycle per REQ-018 and there is no extra register.

Structure
REQ-027 Package bram_arb_pkg SHALL hold MAX_REQ=8, the grant_t one-hot type, and the function rr_pick(valid, last_grant) returning the one-hot grant.
REQ-028 Sub-module rr_arbiter (combinational pick plus the last_grant register) SHALL be instantiated once; the tag pipeline and the BRAM drive stay in the top module.

Verification (bench: sim ROM slave with the file loaded, QUAL_OFFSET=0)
REQ-029 Reset test: reset_n low for 3 cycles with req_valid=2'b11 -> req_ready=0, read_en=0, resp_valid=0 throughout the reset cycles.
REQ-030 Single-requester test: req_valid=2'b01, addr=5 for 4 cycles -> 4 grants; resp_valid=2'b01 starting 1 cycle later with resp_data=rom[5] each cycle (2 cycles later with BRAM_ARB_OUT_REG_EN).
REQ-031 Contention test: both requesters valid, addr0=0, addr1=1, held 6 cycles after reset -> grants alternate 0,1,0,1,0,1; resp_data sequence is rom[0],rom[1],... with the matching resp_valid bit.
REQ-032 Wrap test: NUM_REQ=3, only requesters 2 and 0 valid -> grant order 0,2,0,2; no grant ever goes to requester 1.
REQ-033 Mid-reset test: reset_n pulsed low for 1 cycle immediately after a grant to requester 1 -> no resp_valid in the following 2 cycles.
REQ-034 Idle test: req_valid=0 for 10 cycles -> read_en=0 and read_addr unchanged throughout.
